// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding refill.
// Registered outputs; the RESP bubble ensures a held fetch request is only accepted once per response.
module icache #(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  valid_from_if,
    input  logic [ADDR_WIDTH-1:0] pc_from_if,
    output logic                  valid_to_if,
    output logic [31:0]           inst_to_if,
    output logic                  valid_to_mem,
    output logic [ADDR_WIDTH-1:0] addr_to_mem,
    input  logic                  valid_from_mem,
    input  logic [31:0]           data_from_mem
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {S_IDLE, S_MISS, S_RESP} state_t;

    state_t                  r_state, w_state_nxt;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [31:0]             r_data [LINES];
    logic [INDEX_BITS-1:0]   r_miss_idx, w_miss_idx_nxt;
    logic [TAG_W-1:0]        r_miss_tag, w_miss_tag_nxt;
    logic                    r_valid_to_if, w_valid_to_if_nxt;
    logic [31:0]             r_inst_to_if, w_inst_to_if_nxt;
    logic                    r_valid_to_mem, w_valid_to_mem_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr_to_mem, w_addr_to_mem_nxt;

    logic [INDEX_BITS-1:0]   w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [ADDR_WIDTH-1:0]   w_aligned;
    logic                    w_hit;
    logic                    w_fill;

    assign w_idx     = pc_from_if[INDEX_BITS+1:2];
    assign w_tag     = pc_from_if[ADDR_WIDTH-1:INDEX_BITS+2];
    // Masking (rather than slicing) keeps the ignored low address bits in the datapath.
    assign w_aligned = pc_from_if & ~ADDR_WIDTH'(3);
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_comb begin
        w_state_nxt        = r_state;
        w_miss_idx_nxt     = r_miss_idx;
        w_miss_tag_nxt     = r_miss_tag;
        w_valid_to_if_nxt  = r_valid_to_if;
        w_inst_to_if_nxt   = r_inst_to_if;
        w_valid_to_mem_nxt = r_valid_to_mem;
        w_addr_to_mem_nxt  = r_addr_to_mem;
        w_fill             = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_from_if) begin
                    if (w_hit) begin
                        w_valid_to_if_nxt = 1'b1;
                        w_inst_to_if_nxt  = r_data[w_idx];
                        w_state_nxt       = S_RESP;
                    end else begin
                        w_valid_to_mem_nxt = 1'b1;
                        w_addr_to_mem_nxt  = w_aligned;
                        w_miss_idx_nxt     = w_idx;
                        w_miss_tag_nxt     = w_tag;
                        w_state_nxt        = S_MISS;
                    end
                end
            end
            S_MISS: begin
                if (valid_from_mem) begin
                    w_fill             = 1'b1;
                    w_valid_to_mem_nxt = 1'b0;
                    w_valid_to_if_nxt  = 1'b1;
                    w_inst_to_if_nxt   = data_from_mem;
                    w_state_nxt        = S_RESP;
                end
            end
            S_RESP: begin
                w_valid_to_if_nxt = 1'b0;
                w_state_nxt       = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_valid        <= '0;
            r_miss_idx     <= '0;
            r_miss_tag     <= '0;
            r_valid_to_if  <= 1'b0;
            r_inst_to_if   <= '0;
            r_valid_to_mem <= 1'b0;
            r_addr_to_mem  <= '0;
        end else if (rdy) begin
            r_state        <= w_state_nxt;
            r_miss_idx     <= w_miss_idx_nxt;
            r_miss_tag     <= w_miss_tag_nxt;
            r_valid_to_if  <= w_valid_to_if_nxt;
            r_inst_to_if   <= w_inst_to_if_nxt;
            r_valid_to_mem <= w_valid_to_mem_nxt;
            r_addr_to_mem  <= w_addr_to_mem_nxt;
            if (w_fill)
                r_valid[r_miss_idx] <= 1'b1;
        end
    end

    // Tag/data storage is unreset; the valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        if (rdy && w_fill) begin
            r_tag[r_miss_idx]  <= r_miss_tag;
            r_data[r_miss_idx] <= data_from_mem;
        end
    end

    assign valid_to_if  = r_valid_to_if;
    assign inst_to_if   = r_inst_to_if;
    assign valid_to_mem = r_valid_to_mem;
    assign addr_to_mem  = r_addr_to_mem;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict eviction, held request, rdy stall, reset mid-refill.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        valid_from_if;
    logic [31:0] pc_from_if;
    logic        valid_to_if;
    logic [31:0] inst_to_if;
    logic        valid_to_mem;
    logic [31:0] addr_to_mem;
    logic        valid_from_mem;
    logic [31:0] data_from_mem;

    int n_chk  = 0;
    int n_fail = 0;

    icache dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .valid_from_if  (valid_from_if),
        .pc_from_if     (pc_from_if),
        .valid_to_if    (valid_to_if),
        .inst_to_if     (inst_to_if),
        .valid_to_mem   (valid_to_mem),
        .addr_to_mem    (addr_to_mem),
        .valid_from_mem (valid_from_mem),
        .data_from_mem  (data_from_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full fetch transaction. Misses wait lat cycles before the memory pulse.
    task automatic fetch(input string tag, input logic [31:0] pc, input bit exp_hit,
                         input logic [31:0] mem_word, input int lat, input logic [31:0] exp_inst);
        valid_from_if = 1'b1;
        pc_from_if    = pc;
        tick();
        if (exp_hit) begin
            chk({tag, ".hit_vif"}, valid_to_if, 1);
            chk({tag, ".hit_inst"}, inst_to_if, exp_inst);
            chk({tag, ".hit_vtm"}, valid_to_mem, 0);
        end else begin
            chk({tag, ".miss_vtm"}, valid_to_mem, 1);
            chk({tag, ".miss_addr"}, addr_to_mem, {pc[31:2], 2'b00});
            chk({tag, ".miss_vif"}, valid_to_if, 0);
            pc_from_if = 32'hFFFF_FFF0;
            for (int i = 0; i < lat; i++) begin
                tick();
                chk({tag, ".hold_vtm"}, valid_to_mem, 1);
                chk({tag, ".hold_addr"}, addr_to_mem, {pc[31:2], 2'b00});
                chk({tag, ".hold_vif"}, valid_to_if, 0);
            end
            valid_from_mem = 1'b1;
            data_from_mem  = mem_word;
            tick();
            valid_from_mem = 1'b0;
            data_from_mem  = 32'h0;
            chk({tag, ".fill_vif"}, valid_to_if, 1);
            chk({tag, ".fill_inst"}, inst_to_if, exp_inst);
            chk({tag, ".fill_vtm"}, valid_to_mem, 0);
        end
        valid_from_if = 1'b0;
        tick();
        chk({tag, ".resp_vif"}, valid_to_if, 0);
        chk({tag, ".resp_inst"}, inst_to_if, exp_inst);
    endtask

    initial begin
        rst            = 1'b0;
        rdy            = 1'b1;
        valid_from_if  = 1'b0;
        pc_from_if     = 32'h0;
        valid_from_mem = 1'b0;
        data_from_mem  = 32'h0;
        tick();
        tick();
        chk("rst.vif", valid_to_if, 0);
        chk("rst.inst", inst_to_if, 0);
        chk("rst.vtm", valid_to_mem, 0);
        chk("rst.addr", addr_to_mem, 0);
        rst = 1'b1;
        tick();

        fetch("cold", 32'h0000_0000, 0, 32'h0000_0013, 3, 32'h0000_0013);
        fetch("hit0", 32'h0000_0000, 1, 32'h0, 0, 32'h0000_0013);

        fetch("conf_a", 32'h0000_0004, 0, 32'h0000_00AA, 2, 32'h0000_00AA);
        fetch("conf_a_hit", 32'h0000_0004, 1, 32'h0, 0, 32'h0000_00AA);
        fetch("conf_b", 32'h0000_0044, 0, 32'h0000_00BB, 1, 32'h0000_00BB);
        fetch("conf_a2", 32'h0000_0004, 0, 32'h0000_00CC, 1, 32'h0000_00CC);
        fetch("conf_a2_hit", 32'h0000_0006, 1, 32'h0, 0, 32'h0000_00CC);
        fetch("hit0b", 32'h0000_0000, 1, 32'h0, 0, 32'h0000_0013);

        // Held request: second acceptance only after the RESP bubble.
        valid_from_if = 1'b1;
        pc_from_if    = 32'h0000_0000;
        tick();
        chk("held.first", valid_to_if, 1);
        tick();
        chk("held.bubble", valid_to_if, 0);
        tick();
        chk("held.second", valid_to_if, 1);
        valid_from_if = 1'b0;
        tick();
        chk("held.end", valid_to_if, 0);

        // rdy low during MISS and during RESP freezes everything.
        valid_from_if = 1'b1;
        pc_from_if    = 32'h0000_0008;
        tick();
        chk("stall.vtm0", valid_to_mem, 1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall.vtm", valid_to_mem, 1);
            chk("stall.addr", addr_to_mem, 32'h0000_0008);
            chk("stall.vif", valid_to_if, 0);
        end
        rdy = 1'b1;
        tick();
        chk("stall.after_vtm", valid_to_mem, 1);
        valid_from_mem = 1'b1;
        data_from_mem  = 32'h0000_0055;
        tick();
        valid_from_mem = 1'b0;
        chk("stall.fill_vif", valid_to_if, 1);
        chk("stall.fill_inst", inst_to_if, 32'h0000_0055);
        rdy = 1'b0;
        tick();
        chk("stall.resp_frozen", valid_to_if, 1);
        rdy = 1'b1;
        valid_from_if = 1'b0;
        tick();
        chk("stall.resp_vif", valid_to_if, 0);
        fetch("stall_hit", 32'h0000_0008, 1, 32'h0, 0, 32'h0000_0055);

        // Stray memory pulse in IDLE must not fill line 3.
        valid_from_mem = 1'b1;
        data_from_mem  = 32'h0000_0BAD;
        tick();
        valid_from_mem = 1'b0;
        chk("stray_idle.vif", valid_to_if, 0);
        fetch("stray_idle", 32'h0000_000C, 0, 32'h0000_0077, 1, 32'h0000_0077);

        // Reset in the middle of a refill, then a late memory response.
        valid_from_if = 1'b1;
        pc_from_if    = 32'h0000_0100;
        tick();
        chk("rstmiss.vtm", valid_to_mem, 1);
        rst = 1'b0;
        #2;
        chk("rstmiss.async_vtm", valid_to_mem, 0);
        chk("rstmiss.async_addr", addr_to_mem, 0);
        chk("rstmiss.async_vif", valid_to_if, 0);
        valid_from_if = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        valid_from_mem = 1'b1;
        data_from_mem  = 32'hDEAD_BEEF;
        tick();
        valid_from_mem = 1'b0;
        chk("rstmiss.stray_vif", valid_to_if, 0);
        chk("rstmiss.stray_vtm", valid_to_mem, 0);
        tick();
        chk("rstmiss.stray_vif2", valid_to_if, 0);
        fetch("post_rst", 32'h0000_0000, 0, 32'h0000_0013, 2, 32'h0000_0013);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
